// File: rtl/cnn_noc_pkg.sv
// cnn_noc_pkg: NoC packet field offsets, receiver state and size codes
package cnn_noc_pkg;
  localparam int DIR_LSB = 0;
  localparam int XHOP_LSB = 2;
  localparam int YHOP_LSB = 5;
  localparam int TS_BIT = 8;
  localparam int TYPE_BIT = 9;
  localparam int FROW_LSB = 10;
  localparam int DATA_LSB = 13;
  localparam int SIZE_LSB = 13;
  localparam int CONV_LSB = 15;
  localparam int IFMAP_W = 25;
  localparam int ACK_TYPE_BIT = 0;
  localparam int ACK_NODE_LSB = 1;
  typedef enum logic [1:0] {LOAD, START, BUSY, ACK} rx_state_t;
  typedef enum logic [1:0] {SZ3, SZ4, SZ5, SZ_BAD} size_code_t;
  function automatic logic [4:0] size_mask(size_code_t s);
    return s == SZ3 ? 5'b00111 : s == SZ4 ? 5'b01111 : s == SZ5 ? 5'b11111 : 5'b00000;
  endfunction
endpackage

// File: rtl/pe_packet_receiver_if.sv
// pe_packet_receiver_if: router-side packet input and ack output handshakes
interface pe_packet_receiver_if #(parameter int FILTER_WIDTH = 8);
  logic in_valid;
  logic in_ready;
  logic [5*FILTER_WIDTH+12:0] in_pkt;
  logic ack_valid;
  logic ack_ready;
  logic [5*FILTER_WIDTH+4:0] ack_pkt;
  modport master (output in_valid, in_pkt, ack_ready, input in_ready, ack_valid, ack_pkt);
  modport slave (input in_valid, in_pkt, ack_ready, output in_ready, ack_valid, ack_pkt);
endinterface

// File: rtl/pe_pkt_field_decoder.sv
// pe_pkt_field_decoder: splits a NoC packet into typed fields and flags zero remaining hops
module pe_pkt_field_decoder
  import cnn_noc_pkg::*;
#(
  parameter int FILTER_WIDTH = 8
) (
  input  logic [5*FILTER_WIDTH+12:0] pkt,
  output logic [5*FILTER_WIDTH-1:0] data,
  output logic [2:0] frow,
  output logic is_filter,
  output logic ts,
  output logic hop_ok,
  output logic [IFMAP_W-1:0] ifmap,
  output logic [5*FILTER_WIDTH-28:0] conv_loc,
  output size_code_t size
);
  localparam int IN_W = 5*FILTER_WIDTH + 13;
  logic [1:0] unused_dir;
  assign unused_dir = pkt[DIR_LSB +: 2];
  assign data = pkt[IN_W-1:DATA_LSB];
  assign frow = pkt[FROW_LSB +: 3];
  assign is_filter = pkt[TYPE_BIT];
  assign ts = pkt[TS_BIT];
  assign hop_ok = pkt[XHOP_LSB +: 3] == 3'd0 && pkt[YHOP_LSB +: 3] == 3'd0;
  assign ifmap = pkt[IN_W-1 -: IFMAP_W];
  assign conv_loc = pkt[IN_W-26:CONV_LSB];
  assign size = size_code_t'(pkt[SIZE_LSB +: 2]);
endmodule

// File: rtl/pe_packet_receiver.sv
// pe_packet_receiver: PE NoC endpoint collecting filter rows, launching conv jobs and returning acks.
// Define PE_RX_STATS_EN to add saturating stat_filt/stat_ifmap/stat_drop counters.
module pe_packet_receiver
  import cnn_noc_pkg::*;
#(
  parameter int FILTER_WIDTH = 8,
  parameter int PE_NODE = 0
) (
  input  logic clk,
  input  logic rst,
  pe_packet_receiver_if.slave bus,
  output logic [25*FILTER_WIDTH-1:0] pe_filter,
  output logic [IFMAP_W-1:0] pe_ifmap,
  output logic [5*FILTER_WIDTH-28:0] pe_conv_loc,
  output logic [1:0] pe_size,
  output logic pe_timestep,
  output logic pe_start,
  input  logic pe_done,
  output logic err_hop,
  output logic err_filter
`ifdef PE_RX_STATS_EN
  ,
  output logic [15:0] stat_filt,
  output logic [15:0] stat_ifmap,
  output logic [15:0] stat_drop
`endif
);
  localparam int RW = 5*FILTER_WIDTH;
  localparam int ACK_W = RW + 5;
  localparam logic [ACK_W-1:0] ACK_PKT = (ACK_W'(PE_NODE % 16) << ACK_NODE_LSB) & ~(ACK_W'(1) << ACK_TYPE_BIT);
  rx_state_t state, state_nx;
  logic live, stale, acc, row_ok, job_ok, filt_pkt, filt_wr, job_go;
  logic [4:0] mask, need;
  logic [RW-1:0] data;
  logic [2:0] frow;
  logic is_filter, ts, hop_ok;
  logic [IFMAP_W-1:0] ifmap;
  logic [RW-28:0] conv_loc;
  size_code_t size;
  pe_pkt_field_decoder #(.FILTER_WIDTH(FILTER_WIDTH)) u_dec (
    .pkt(bus.in_pkt), .data, .frow, .is_filter, .ts, .hop_ok, .ifmap, .conv_loc, .size
  );
  // live holds in_ready low for the first cycle after reset release
  assign bus.in_ready = live && state == LOAD;
  assign bus.ack_valid = state == ACK;
  assign bus.ack_pkt = bus.ack_valid ? ACK_PKT : '0;
  assign pe_start = state == START;
  always_comb begin
    acc = bus.in_valid && bus.in_ready;
    need = size_mask(size);
    row_ok = frow < 3'd5;
    job_ok = size != SZ_BAD && (mask & need) == need;
    filt_pkt = acc && hop_ok && is_filter;
    filt_wr = filt_pkt && row_ok;
    job_go = acc && hop_ok && !is_filter && job_ok;
    state_nx = state == LOAD ? (job_go ? START : LOAD) :
               state == START ? BUSY :
               state == BUSY ? (pe_done ? ACK : BUSY) :
               (bus.ack_ready ? LOAD : ACK);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else state <= state_nx;
  end
  // a stale filter stays usable until the first new filter row replaces the whole set
  always_ff @(posedge clk) begin
    if (rst) begin
      live <= 1'b0;
      stale <= 1'b0;
      mask <= '0;
      pe_filter <= '0;
      pe_ifmap <= '0;
      pe_conv_loc <= '0;
      pe_size <= '0;
      pe_timestep <= 1'b0;
      err_hop <= 1'b0;
      err_filter <= 1'b0;
    end else begin
      live <= 1'b1;
      err_hop <= acc && !hop_ok;
      err_filter <= acc && hop_ok && !filt_wr && !job_go;
      if (pe_start) stale <= 1'b1;
      if (filt_pkt) begin
        stale <= 1'b0;
        mask <= (stale ? 5'd0 : mask) | (row_ok ? 5'd1 << frow : 5'd0);
      end
      if (filt_wr) pe_filter[int'(frow)*RW +: RW] <= data;
      if (job_go) begin
        pe_ifmap <= ifmap;
        pe_conv_loc <= conv_loc;
        pe_size <= size;
        pe_timestep <= ts;
      end
    end
  end
`ifdef PE_RX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_filt <= '0;
      stat_ifmap <= '0;
      stat_drop <= '0;
    end else begin
      if (filt_wr && ~&stat_filt) stat_filt <= stat_filt + 16'd1;
      if (job_go && ~&stat_ifmap) stat_ifmap <= stat_ifmap + 16'd1;
      if (acc && !filt_wr && !job_go && ~&stat_drop) stat_drop <= stat_drop + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pe_packet_receiver.sv
// tb_pe_packet_receiver: scenario bench with an expected-response queue per accepted packet
module tb_pe_packet_receiver;
  localparam logic [2:0] OK = 3'b000, HOP = 3'b100, FE = 3'b010, GO = 3'b001;
  localparam logic [24:0] IFM = 25'h1ABCDEF;
  localparam logic [12:0] CONV = 13'h0123;
  localparam logic [39:0] R0 = 40'h0102030405, R1 = 40'h1112131415, R2 = 40'h2122232425;
  localparam logic [39:0] N0 = 40'hA0A1A2A3A4, N1 = 40'hB0B1B2B3B4;
  localparam logic [44:0] ACKX = 45'hA;
  logic clk = 0, rst = 1, pe_done = 0;
  logic [199:0] pe_filter;
  logic [24:0] pe_ifmap;
  logic [12:0] pe_conv_loc;
  logic [1:0] pe_size;
  logic pe_timestep, pe_start, err_hop, err_filter;
`ifdef PE_RX_STATS_EN
  logic [15:0] stat_filt, stat_ifmap, stat_drop;
`endif
  int n_cmp = 0, n_bad = 0;
  logic [2:0] obs, e;
  logic [2:0] exp_q[$];
  pe_packet_receiver_if #(.FILTER_WIDTH(8)) bus ();
  pe_packet_receiver #(.FILTER_WIDTH(8), .PE_NODE(5)) dut (
    .clk(clk), .rst(rst), .bus(bus), .pe_filter(pe_filter), .pe_ifmap(pe_ifmap),
    .pe_conv_loc(pe_conv_loc), .pe_size(pe_size), .pe_timestep(pe_timestep), .pe_start(pe_start),
    .pe_done(pe_done), .err_hop(err_hop), .err_filter(err_filter)
`ifdef PE_RX_STATS_EN
    , .stat_filt(stat_filt), .stat_ifmap(stat_ifmap), .stat_drop(stat_drop)
`endif
  );
  always #5 clk = ~clk;

  function automatic logic [52:0] pk(input logic f, input logic [2:0] row, input logic [39:0] d,
                                     input logic [2:0] xh, input logic [2:0] yh, input logic t);
    return {d, row, f, t, yh, xh, 2'b01};
  endfunction
  function automatic logic [52:0] im(input logic [1:0] sz, input logic t);
    return pk(1'b0, 3'd0, {IFM, CONV, sz}, 3'd0, 3'd0, t);
  endfunction
  function automatic logic all_zero();
    return {pe_start, bus.ack_valid, bus.in_ready, err_hop, err_filter, pe_timestep, pe_size} === 9'b0 &&
           pe_filter === '0 && pe_ifmap === '0 && pe_conv_loc === '0 && bus.ack_pkt === '0;
  endfunction

  task automatic send(input logic [52:0] p, input logic [2:0] x);
    int w = 0;
    exp_q.push_back(x);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_pkt = p;
    while (bus.in_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (bus.in_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL in_ready_timeout got %b want 1", bus.in_ready);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    obs = {err_hop, err_filter, pe_start};
  endtask

  task automatic finish_job(input string tag);
    @(negedge clk); pe_done = 1'b1;
    @(negedge clk); pe_done = 1'b0;
    n_cmp++;
    if (bus.ack_valid !== 1'b1) begin n_bad++; $display("FAIL %s_ack_valid got %b want 1", tag, bus.ack_valid); end
    bus.ack_ready = 1'b1;
    @(negedge clk); bus.ack_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (!all_zero()) begin
      n_bad++;
      $display("FAIL reset_outputs start=%b ack_v=%b rdy=%b err=%b%b filt=%h want all 0", pe_start, bus.ack_valid, bus.in_ready, err_hop, err_filter, pe_filter);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL in_ready_at_release got %b want 0", bus.in_ready); end
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL in_ready_after_reset got %b want 1", bus.in_ready); end
  endtask

  task automatic test_load_job;
    logic [52:0] p[4];
    logic [2:0] x[4];
    p = '{pk(1'b1, 3'd0, R0, 3'd0, 3'd0, 1'b0), pk(1'b1, 3'd1, R1, 3'd0, 3'd0, 1'b0), pk(1'b1, 3'd2, R2, 3'd0, 3'd0, 1'b0), im(2'b00, 1'b1)};
    x = '{OK, OK, OK, GO};
    for (int i = 0; i < 4; i++) begin
      send(p[i], x[i]); e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL load_job pkt%0d {hop,filt,start} got %b want %b", i, obs, e); end
    end
    n_cmp++;
    if (pe_timestep !== 1'b1 || pe_filter[39:0] !== R0 || pe_filter[119:80] !== R2 || pe_ifmap !== IFM || pe_conv_loc !== CONV || pe_size !== 2'b00) begin
      n_bad++;
      $display("FAIL load_job_fields ts=%b row0=%h row2=%h ifmap=%h loc=%h size=%b want 1 %h %h %h %h 00", pe_timestep, pe_filter[39:0], pe_filter[119:80], pe_ifmap, pe_conv_loc, pe_size, R0, R2, IFM, CONV);
    end
    @(negedge clk);
    n_cmp++;
    if (pe_start !== 1'b0 || bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL start_one_cycle start=%b rdy=%b want 0 0", pe_start, bus.in_ready); end
  endtask

  task automatic test_ack;
    bus.ack_ready = 1'b0;
    pe_done = 1'b1;
    @(negedge clk); pe_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bus.ack_valid !== 1'b1 || bus.ack_pkt !== ACKX || bus.in_ready !== 1'b0) begin
        n_bad++; $display("FAIL ack_hold%0d valid=%b pkt=%h rdy=%b want 1 %h 0", i, bus.ack_valid, bus.ack_pkt, bus.in_ready, ACKX);
      end
      @(negedge clk);
    end
    bus.ack_ready = 1'b1;
    @(negedge clk); bus.ack_ready = 1'b0;
    n_cmp++;
    if (bus.ack_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL ack_release valid=%b rdy=%b want 0 1", bus.ack_valid, bus.in_ready); end
    pe_done = 1'b1;
    repeat (2) @(negedge clk);
    pe_done = 1'b0;
    n_cmp++;
    if (bus.ack_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL done_in_load valid=%b rdy=%b want 0 1", bus.ack_valid, bus.in_ready); end
  endtask

  task automatic test_reuse;
    logic [52:0] p[5];
    logic [2:0] x[5];
    p = '{pk(1'b1, 3'd0, N0, 3'd1, 3'd0, 1'b0), pk(1'b1, 3'd1, N1, 3'd0, 3'd4, 1'b0), pk(1'b1, 3'd5, N0, 3'd1, 3'd0, 1'b0),
          pk(1'b0, 3'd0, {IFM, CONV, 2'b00}, 3'd0, 3'd2, 1'b0), im(2'b00, 1'b0)};
    x = '{HOP, HOP, HOP, HOP, GO};
    for (int i = 0; i < 5; i++) begin
      send(p[i], x[i]); e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL reuse pkt%0d {hop,filt,start} got %b want %b", i, obs, e); end
    end
    n_cmp++;
    if (pe_filter[39:0] !== R0 || pe_filter[79:40] !== R1 || pe_timestep !== 1'b0) begin
      n_bad++; $display("FAIL reuse_rows row0=%h row1=%h ts=%b want %h %h 0", pe_filter[39:0], pe_filter[79:40], pe_timestep, R0, R1);
    end
    finish_job("reuse");
  endtask

  task automatic test_stale;
    logic [52:0] p[9];
    logic [2:0] x[9];
    p = '{pk(1'b1, 3'd0, N0, 3'd0, 3'd0, 1'b0), im(2'b00, 1'b0), pk(1'b1, 3'd5, N1, 3'd0, 3'd0, 1'b0),
          pk(1'b1, 3'd1, N1, 3'd0, 3'd0, 1'b0), im(2'b00, 1'b0), im(2'b11, 1'b0),
          pk(1'b1, 3'd2, R2, 3'd0, 3'd0, 1'b0), im(2'b01, 1'b0), im(2'b00, 1'b0)};
    x = '{OK, FE, FE, OK, FE, FE, OK, FE, GO};
    for (int i = 0; i < 9; i++) begin
      send(p[i], x[i]); e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL stale pkt%0d {hop,filt,start} got %b want %b", i, obs, e); end
    end
    n_cmp++;
    if (pe_filter[39:0] !== N0 || pe_filter[79:40] !== N1 || pe_size !== 2'b00) begin
      n_bad++; $display("FAIL stale_rows row0=%h row1=%h size=%b want %h %h 00", pe_filter[39:0], pe_filter[79:40], pe_size, N0, N1);
    end
    finish_job("stale");
  endtask

  task automatic test_rst_mid;
    logic [52:0] p[8];
    logic [2:0] x[8];
    send(im(2'b00, 1'b0), GO); e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL rst_busy_start got %b want %b", obs, e); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (!all_zero()) begin n_bad++; $display("FAIL rst_in_busy start=%b rdy=%b filt=%h ifmap=%h want all 0", pe_start, bus.in_ready, pe_filter, pe_ifmap); end
    rst = 1'b0;
    p = '{im(2'b00, 1'b0), pk(1'b1, 3'd0, R0, 3'd0, 3'd0, 1'b0), pk(1'b1, 3'd1, R1, 3'd0, 3'd0, 1'b0), pk(1'b1, 3'd2, R2, 3'd0, 3'd0, 1'b0),
          pk(1'b1, 3'd3, N0, 3'd0, 3'd0, 1'b0), im(2'b10, 1'b1), pk(1'b1, 3'd4, N1, 3'd0, 3'd0, 1'b0), im(2'b10, 1'b1)};
    x = '{FE, OK, OK, OK, OK, FE, OK, GO};
    for (int i = 0; i < 8; i++) begin
      send(p[i], x[i]); e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL rst_reload pkt%0d {hop,filt,start} got %b want %b", i, obs, e); end
    end
    n_cmp++;
    if (pe_filter[199:160] !== N1 || pe_size !== 2'b10 || pe_timestep !== 1'b1) begin
      n_bad++; $display("FAIL size5_job row4=%h size=%b ts=%b want %h 10 1", pe_filter[199:160], pe_size, pe_timestep, N1);
    end
    @(negedge clk); pe_done = 1'b1;
    @(negedge clk); pe_done = 1'b0;
    n_cmp++;
    if (bus.ack_valid !== 1'b1) begin n_bad++; $display("FAIL rst_ack_valid got %b want 1", bus.ack_valid); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (!all_zero()) begin n_bad++; $display("FAIL rst_in_ack ack_v=%b pkt=%h filt=%h want all 0", bus.ack_valid, bus.ack_pkt, pe_filter); end
`ifdef PE_RX_STATS_EN
    n_cmp++;
    if ({stat_filt, stat_ifmap, stat_drop} !== 48'b0) begin n_bad++; $display("FAIL rst_stats got %h %h %h want 0", stat_filt, stat_ifmap, stat_drop); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_pkt = '0;
    bus.ack_ready = 1'b0;
    test_reset();
    test_load_job();
    test_ack();
    test_reuse();
    test_stale();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
